lea_key_schedule: RTL

- Sequential LEA-128 key-schedule generator. It sits directly upstream of the combinational LEA round-encrypt stage and supplies that stage's 192-bit RoundKey input one round at a time.
- It loads a 128-bit master key and produces round keys 0..23 in order over a valid/ready handshake, at up to one key per cycle.
- The consuming round controller pairs each accepted key with one round-function evaluation.

---
 rtl/lea_key_schedule_pkg.sv | 29 ++
 rtl/lea_key_schedule_if.sv | 27 ++
 rtl/lea_key_schedule_ks_round.sv | 24 ++
 rtl/lea_key_schedule.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lea_key_schedule_pkg.sv
// Shared LEA-128 key-schedule types, constants and rotate helpers.
// Used by lea_key_schedule (optional reverse mode via LEA_KS_REVERSE_EN).
package lea_pkg;

    localparam int NUM_ROUNDS_128 = 24;

    localparam logic [31:0] LEA_DELTA [0:3] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec
    };

    typedef logic [191:0]     round_key_t;
    typedef logic [3:0][31:0] ks_words_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PRECOMP
    } ks_state_t;

    // A shift amount of (0 - n) wraps to 32 - n, and to 0 when n is 0.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (5'd0 - n));
    endfunction

    function automatic round_key_t rk_map(input ks_words_t t);
        return {t[1], t[3], t[1], t[2], t[1], t[0]};
    endfunction

endpackage

// File: rtl/lea_key_schedule_if.sv
// Round-key stream from the key schedule to the round controller.
// master drives the key; slave accepts it with RkReady.
interface lea_key_schedule_if #(
    parameter int CNT_W = 5
);
    import lea_pkg::*;

    logic             RkValid;
    logic             RkReady;
    round_key_t       RoundKey;
    logic [CNT_W-1:0] RoundIdx;

    modport master (
        output RkValid,
        output RoundKey,
        output RoundIdx,
        input  RkReady
    );

    modport slave (
        input  RkValid,
        input  RoundKey,
        input  RoundIdx,
        output RkReady
    );

endinterface

// File: rtl/lea_key_schedule_ks_round.sv
// One LEA-128 key-schedule step: next T0..T3 from current T and round index.
// Purely combinational; the round index selects and rotates the delta.
module lea_ks_round
    import lea_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  ks_words_t        t_i,
    input  logic [CNT_W-1:0] round_i,
    output ks_words_t        t_o
);

    logic [31:0] delta;
    logic [4:0]  rot;

    assign delta = LEA_DELTA[round_i[1:0]];
    assign rot   = 5'(round_i);

    assign t_o[0] = rol32(t_i[0] + rol32(delta, rot),         5'd1);
    assign t_o[1] = rol32(t_i[1] + rol32(delta, rot + 5'd1),  5'd3);
    assign t_o[2] = rol32(t_i[2] + rol32(delta, rot + 5'd2),  5'd6);
    assign t_o[3] = rol32(t_i[3] + rol32(delta, rot + 5'd3),  5'd11);

endmodule

// File: rtl/lea_key_schedule.sv
// LEA-128 key schedule: emits round keys 0..23 over a valid/ready stream.
// Define LEA_KS_REVERSE_EN for the Decrypt input and buffered reverse order.
module lea_key_schedule
    import lea_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_128,
    parameter int CNT_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Start,
    input  logic [127:0]        Key,
`ifdef LEA_KS_REVERSE_EN
    input  logic                Decrypt,
`endif
    output logic                Busy,
    output logic                Done,
    lea_key_schedule_if.master  rk
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

    ks_state_t        state_q, state_d;
    ks_words_t        t_q, t_d, src_t, nxt_t;
    logic [CNT_W-1:0] idx_q, idx_d, round_sel;
    logic             done_q, done_d;
    logic             hs;
`ifdef LEA_KS_REVERSE_EN
    logic             rev_q, rev_d;
    round_key_t       buf_q [NUM_ROUNDS];
`endif

    // Loading from IDLE evaluates round 0 on the master key directly.
    assign src_t     = (state_q == IDLE) ? ks_words_t'(Key) : t_q;
    assign round_sel = (state_q == IDLE) ? '0 : idx_q + 1'b1;

    lea_ks_round #(.CNT_W(CNT_W)) u_round (
        .t_i     (src_t),
        .round_i (round_sel),
        .t_o     (nxt_t)
    );

    assign rk.RkValid  = (state_q == RUN);
    assign rk.RoundIdx = idx_q;
    assign hs          = rk.RkValid & rk.RkReady;
    assign Busy        = (state_q != IDLE);
    assign Done        = done_q;

`ifdef LEA_KS_REVERSE_EN
    assign rk.RoundKey = rev_q ? buf_q[idx_q] : rk_map(t_q);
`else
    assign rk.RoundKey = rk_map(t_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef LEA_KS_REVERSE_EN
            rev_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef LEA_KS_REVERSE_EN
            rev_q   <= rev_d;
`endif
        end
    end

`ifdef LEA_KS_REVERSE_EN
    // Key storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == PRECOMP) begin
            buf_q[idx_q] <= rk_map(t_q);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef LEA_KS_REVERSE_EN
        rev_d   = rev_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    t_d     = nxt_t;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef LEA_KS_REVERSE_EN
                    rev_d   = Decrypt;
                    if (Decrypt) state_d = PRECOMP;
`endif
                end
            end
            RUN: begin
                if (hs) begin
`ifdef LEA_KS_REVERSE_EN
                    if (rev_q ? (idx_q == '0) : (idx_q == LAST)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        rev_d   = 1'b0;
                    end else if (rev_q) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        t_d   = nxt_t;
                        idx_d = idx_q + 1'b1;
                    end
`else
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        t_d   = nxt_t;
                        idx_d = idx_q + 1'b1;
                    end
`endif
                end
            end
`ifdef LEA_KS_REVERSE_EN
            // Index ends at LAST, which is where reverse emission starts.
            PRECOMP: begin
                if (idx_q == LAST) begin
                    state_d = RUN;
                end else begin
                    t_d   = nxt_t;
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
